weight_update_decode: RTL and testbench
=======================================

# weight_update_decode

Consumes the diff-to-decode pipeline bundle and turns each `update_weight` strobe into a serial read-modify-write of one weight row in the external weight memory: w_new = sat(w − (dc_dw >>> lr_shift)). It sits directly after the diff-to-decode register stage and is the decode-side end of that interface. The upstream register has no stall path, so a one-entry pending slot absorbs an update that arrives while a row is in progress. An overflow flag records dropped updates.

## Interface
- `size`, 3: elements per row (dc_dw lanes)
- `data_size`, 16: signed element width
- `lr_shift`, 4: learning-rate right shift applied to dc_dw
- `clk`  in  1: rising-edge clock
- `rst_n`  in  1: asynchronous, active-low reset
- `update_weight`  in  1: single-cycle strobe; bundle fields valid this cycle
- `w_layer_index`  in  32: target layer
- `w_row_index`  in  32: target row
- `dc_dw`  in  data_size*size: gradient; lane i = bits [data_size*(i+1)-1 : data_size*i]
- `predict_value`, `z`  in  data_size*size: accepted for interface compatibility, unused
- `mem_rd_en`  out  1: weight read request
- `mem_wr_en`  out  1: weight write strobe
- `mem_layer`, `mem_row`, `mem_col`  out  32 each: memory address
- `mem_rd_data`  in  data_size: read data, valid exactly 1 cycle after `mem_rd_en`
- `mem_wr_data`  out  data_size: write data
- `busy`  out  1: a row update is active
- `done`  out  1: 1-cycle pulse coincident with the last write of a row
- `overflow`  out  1: sticky; set when an update is dropped
- `update_count`  out  32: completed row updates, wraps at 2^32

## Operation
- State machine: IDLE, READ, WRITE.
- Active registers: layer, row, dc_dw, col counter.
- Pending slot: valid bit plus layer, row and dc_dw.
- IDLE:
  - `update_weight`=1 loads the active registers, sets col=0 and moves to READ.
- READ:
  - `mem_rd_en`=1; address = {active layer, row, col}.
  - Next state is WRITE.
- WRITE:
  - `mem_wr_en`=1 at the same address.
  - `mem_wr_data` = sat(mem_rd_data − (lane[col] >>> lr_shift)).
  - If col < size−1: col+1, go to READ.
  - Else (last write): assert `done`, increment `update_count`, then:
    - pending valid → load active from pending, clear pending, go to READ;
    - otherwise, `update_weight` this cycle → load active from the input, go to READ;
    - otherwise → IDLE.
- Arithmetic:
  - Arithmetic shift on the signed lane.
  - Subtraction in data_size+1 bits.
  - Saturate to [−2^(data_size−1), 2^(data_size−1)−1].
- Input capture while busy:
  - If the pending slot is empty, or is drained to active this same cycle, the input is written to pending.
  - If pending is full and not draining, the input is dropped and `overflow` is set.
  - Exception: on the last WRITE with pending empty, the input goes directly to active, not to pending.
- `busy` = state ≠ IDLE.
- `mem_*` address outputs hold their last value when no request is asserted. `mem_wr_data` is don't-care when `mem_wr_en`=0.

## Timing
- Reset (async, while `rst_n`=0):
  - state IDLE; pending invalid.
  - `mem_rd_en`, `mem_wr_en`, `busy`, `done`, `overflow` = 0.
  - `update_count`, address outputs, `mem_wr_data` = 0.
- Reset mid-row abandons the row. No further read or write is issued after `rst_n` falls.
- Strobe at edge T from IDLE:
  - `mem_rd_en` in cycle T+1, col 0; `mem_wr_en` in T+2.
  - Lane k is read in T+1+2k and written in T+2+2k.
  - Last write and `done` are in T+2·size.
- Row occupancy is 2·size cycles.
- Back-to-back rows: the next READ follows the previous last WRITE with no IDLE cycle.
- `update_count` increments at the edge ending the `done` cycle.
- Once set, `overflow` stays at 1 until reset.

## Test plan
- Single update, size=3, lr_shift=4:
  - Stimulus: layer 2, row 5, dc_dw lanes {16, −32, 0}; memory holds {100, 100, 100}.
  - Response: writes {99, 102, 100} to cols 0..2 in cycles T+2, T+4, T+6; `done` in T+6; `update_count`=1.
- Saturation:
  - Stimulus: w=−32760, lane=+32767 (delta 2047).
  - Response: writes −32768. Mirror case w=32760, lane=−32768 writes 32767.
- Pending slot:
  - Stimulus: second strobe at T+3 (layer 3).
  - Response: its READ of col 0 occurs at T+7, directly after the first row's last write; no IDLE cycle.
- Overflow:
  - Stimulus: strobes at T, T+2, T+4.
  - Response: the third strobe is dropped; `overflow`=1 from T+5; exactly 2 rows are written.
- Simultaneous:
  - Stimulus: strobe coincident with the last WRITE (T+6), pending empty.
  - Response: new row READ at T+7; `overflow` stays 0.
- Reset mid-row:
  - Stimulus: `rst_n` low at T+3.
  - Response: all outputs 0 immediately; no `mem_wr_en` for cols 1..2; `update_count`=0.

Source files
------------

// File: rtl/weight_update_decode.sv
// weight_update_decode: turns each update_weight strobe into a serial read-modify-write
// of one weight row, w_new = sat(w - (dc_dw >>> lr_shift)), with a one-entry pending slot.
`default_nettype none

module weight_update_decode #(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int lr_shift  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        update_weight,
  input  logic [31:0]                 w_layer_index,
  input  logic [31:0]                 w_row_index,
  input  logic [data_size*size-1:0]   dc_dw,
  input  logic [data_size*size-1:0]   predict_value,
  input  logic [data_size*size-1:0]   z,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [31:0]                 mem_layer,
  output logic [31:0]                 mem_row,
  output logic [31:0]                 mem_col,
  input  logic [data_size-1:0]        mem_rd_data,
  output logic [data_size-1:0]        mem_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [31:0]                 update_count
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;
  localparam int VW = data_size * size;
  localparam logic [CW-1:0] LAST_COL = CW'(size - 1);
  localparam logic [data_size-1:0] SAT_MAX = {1'b0, {(data_size-1){1'b1}}};
  localparam logic [data_size-1:0] SAT_MIN = {1'b1, {(data_size-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [31:0]     act_layer;
  logic [31:0]     act_row;
  logic [VW-1:0]   act_dw;
  logic            pend_valid;
  logic [31:0]     pend_layer;
  logic [31:0]     pend_row;
  logic [VW-1:0]   pend_dw;

  logic                        last_wr;
  logic                        draining;
  logic                        take_pend;
  logic                        drop;
  logic signed [data_size-1:0] lane;
  logic signed [data_size-1:0] delta;
  logic [data_size:0]          diff;
  logic [data_size-1:0]        wr_val;

  logic unused_inputs;
  assign unused_inputs = ^{predict_value, z};

  always_comb begin
    last_wr  = (state == WRITE) && (col == LAST_COL);
    draining = last_wr && pend_valid;
    // On the last write with an empty slot the input goes straight to active instead.
    take_pend = update_weight && (state != IDLE) && !(last_wr && !pend_valid)
                && (!pend_valid || draining);
    drop      = update_weight && (state != IDLE) && pend_valid && !draining;
  end

  always_comb begin
    lane  = act_dw[int'(col)*data_size +: data_size];
    delta = lane >>> lr_shift;
    diff  = {mem_rd_data[data_size-1], mem_rd_data} - {delta[data_size-1], delta};
    if (diff[data_size] != diff[data_size-1]) begin
      wr_val = diff[data_size] ? SAT_MIN : SAT_MAX;
    end else begin
      wr_val = diff[data_size-1:0];
    end
  end

  assign mem_wr_data = mem_wr_en ? wr_val : '0;
  assign mem_layer   = act_layer;
  assign mem_row     = act_row;
  assign mem_col     = 32'(col);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col          <= '0;
      act_layer    <= '0;
      act_row      <= '0;
      act_dw       <= '0;
      pend_valid   <= 1'b0;
      pend_layer   <= '0;
      pend_row     <= '0;
      pend_dw      <= '0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      update_count <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;

      if (take_pend) begin
        pend_valid <= 1'b1;
        pend_layer <= w_layer_index;
        pend_row   <= w_row_index;
        pend_dw    <= dc_dw;
      end else if (draining) begin
        pend_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (update_weight) begin
            act_layer <= w_layer_index;
            act_row   <= w_row_index;
            act_dw    <= dc_dw;
            col       <= '0;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          mem_wr_en <= 1'b1;
          done      <= (col == LAST_COL);
          state     <= WRITE;
        end
        WRITE: begin
          if (col != LAST_COL) begin
            col       <= col + 1'b1;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end else begin
            update_count <= update_count + 32'd1;
            if (pend_valid) begin
              act_layer <= pend_layer;
              act_row   <= pend_row;
              act_dw    <= pend_dw;
              col       <= '0;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end else if (update_weight) begin
              act_layer <= w_layer_index;
              act_row   <= w_row_index;
              act_dw    <= dc_dw;
              col       <= '0;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_update_decode.sv
// Bench for weight_update_decode: transaction-level row schedule model plus memory model,
// directed test-plan cases with literal expectations, then randomized strobes and resets.
`default_nettype none

module tb_weight_update_decode;

  localparam int S  = 3;
  localparam int DW = 16;
  localparam int LR = 4;

  logic          clk;
  logic          rst_n;
  logic          update_weight;
  logic [31:0]   w_layer_index;
  logic [31:0]   w_row_index;
  logic [47:0]   dc_dw;
  logic [47:0]   predict_value;
  logic [47:0]   z;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [31:0]   mem_layer;
  logic [31:0]   mem_row;
  logic [31:0]   mem_col;
  logic [15:0]   mem_rd_data;
  logic [15:0]   mem_wr_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [31:0]   update_count;

  weight_update_decode #(.size(S), .data_size(DW), .lr_shift(LR)) dut (
    .clk(clk), .rst_n(rst_n), .update_weight(update_weight),
    .w_layer_index(w_layer_index), .w_row_index(w_row_index), .dc_dw(dc_dw),
    .predict_value(predict_value), .z(z),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_layer(mem_layer),
    .mem_row(mem_row), .mem_col(mem_col), .mem_rd_data(mem_rd_data),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done), .overflow(overflow),
    .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          start;
    logic [31:0] layer;
    logic [31:0] row;
    logic [47:0] dw;
  } row_t;

  logic signed [15:0] mm [128];
  row_t               q[$];
  int                 cyc;
  int                 last_end;
  logic [31:0]        done_cnt;
  bit                 ovf;
  logic [31:0]        h_l, h_r, h_c;
  bit                 pw_valid;
  int                 pw_idx;
  logic signed [15:0] pw_val;
  int                 checks;
  int                 errors;

  int                 wr_cyc[$];
  logic signed [15:0] wr_dat[$];
  int                 rd_cyc[$];
  logic [31:0]        rd_lay[$];
  int                 done_cyc[$];

  function automatic int idx(input logic [31:0] l, input logic [31:0] r, input logic [31:0] c);
    return int'({l[1:0], r[2:0], c[1:0]});
  endfunction

  function automatic logic signed [15:0] sat_upd(input logic signed [15:0] w,
                                                 input logic signed [15:0] g);
    int res;
    res = int'(w) - (int'(g) >>> LR);
    if (res > 32767) res = 32767;
    if (res < -32768) res = -32768;
    return 16'(res);
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mm[idx(mem_layer, mem_row, mem_col)];
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    bit e_rd, e_wr, e_done, e_busy;
    int k, ph;
    logic [47:0] dw;
    logic signed [15:0] g, ev;
    if (pw_valid && rst_n) mm[pw_idx] = pw_val;
    pw_valid = 0;
    if (!rst_n) begin
      q.delete();
      last_end = -100;
      done_cnt = 0;
      ovf = 0;
      h_l = 0; h_r = 0; h_c = 0;
    end
    while (q.size() > 0 && q[0].start + 2*S - 1 < cyc) void'(q.pop_front());
    e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0;
    if (rst_n && q.size() > 0 && q[0].start <= cyc) begin
      k  = (cyc - q[0].start) / 2;
      ph = (cyc - q[0].start) % 2;
      e_busy = 1;
      e_rd   = (ph == 0);
      e_wr   = (ph == 1);
      e_done = e_wr && (k == S - 1);
      h_l = q[0].layer; h_r = q[0].row; h_c = k;
    end
    chk("rd_en", mem_rd_en, e_rd);
    chk("wr_en", mem_wr_en, e_wr);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("layer", mem_layer, h_l);
    chk("row", mem_row, h_r);
    chk("col", mem_col, h_c);
    chk("update_count", update_count, done_cnt);
    chk("overflow", overflow, ovf);
    if (!rst_n) chk("wr_data_reset", mem_wr_data, 0);
    if (e_wr) begin
      dw = q[0].dw;
      g  = dw[16*k +: 16];
      ev = sat_upd(mm[idx(h_l, h_r, h_c)], g);
      chk("wr_data", $signed(mem_wr_data), ev);
      pw_valid = 1;
      pw_idx   = idx(h_l, h_r, h_c);
      pw_val   = ev;
    end
    if (mem_wr_en) begin wr_cyc.push_back(cyc); wr_dat.push_back($signed(mem_wr_data)); end
    if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_lay.push_back(mem_layer); end
    if (done) done_cyc.push_back(cyc);
    if (e_done) done_cnt++;
  endtask

  task automatic strobe();
    bit full;
    row_t r;
    if (rst_n && update_weight) begin
      full = 0;
      foreach (q[i]) if (q[i].start > cyc + 1) full = 1;
      if (full) begin
        ovf = 1;
      end else begin
        r.start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        r.layer = w_layer_index;
        r.row   = w_row_index;
        r.dw    = dc_dw;
        q.push_back(r);
        last_end = r.start + 2*S - 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit uw, input logic [31:0] l,
                      input logic [31:0] rw, input logic [47:0] dw);
    @(negedge clk);
    compare();
    rst_n         = r;
    update_weight = uw;
    w_layer_index = l;
    w_row_index   = rw;
    dc_dw         = dw;
    predict_value = rnd48();
    z             = rnd48();
    strobe();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, $urandom(), $urandom(), rnd48());
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    wr_cyc.delete(); wr_dat.delete(); rd_cyc.delete(); rd_lay.delete(); done_cyc.delete();
  endtask

  int t0;
  int mode_dense;
  logic [15:0] lanes [3];
  logic [47:0] rdw;

  initial begin
    checks = 0; errors = 0; cyc = 0; last_end = -100;
    done_cnt = 0; ovf = 0; h_l = 0; h_r = 0; h_c = 0; pw_valid = 0;
    rst_n = 1'b0; update_weight = 1'b0; w_layer_index = '0; w_row_index = '0;
    dc_dw = '0; predict_value = '0; z = '0;
    for (int i = 0; i < 128; i++) mm[i] = 16'($urandom());

    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_count", update_count, 0);

    // Single update: expected writes 99, 102, 100.
    for (int k = 0; k < 3; k++) mm[idx(2, 5, k)] = 16'sd100;
    t0 = cyc;
    tick(1, 1, 2, 5, {16'h0000, 16'hFFE0, 16'h0010});
    idle(9);
    chk("single_nwr", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("single_c0", wr_cyc[0], t0 + 2);
      chk("single_c1", wr_cyc[1], t0 + 4);
      chk("single_c2", wr_cyc[2], t0 + 6);
      chk("single_w0", wr_dat[0], 99);
      chk("single_w1", wr_dat[1], 102);
      chk("single_w2", wr_dat[2], 100);
    end
    chk("single_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("single_done", done_cyc[0], t0 + 6);
    chk("single_count", update_count, 1);

    // Saturation both ways.
    do_reset();
    mm[idx(1, 1, 0)] = -16'sd32760;
    mm[idx(1, 1, 1)] = 16'sd32760;
    mm[idx(1, 1, 2)] = 16'sd5;
    tick(1, 1, 1, 1, {16'h0000, 16'h8000, 16'h7FFF});
    idle(9);
    chk("sat_nwr", wr_dat.size(), 3);
    if (wr_dat.size() == 3) begin
      chk("sat_neg", wr_dat[0], -32768);
      chk("sat_pos", wr_dat[1], 32767);
      chk("sat_none", wr_dat[2], 5);
    end

    // Pending slot: second strobe at T+3 reads at T+7.
    do_reset();
    t0 = cyc;
    tick(1, 1, 0, 0, rnd48());
    idle(2);
    tick(1, 1, 3, 1, rnd48());
    idle(16);
    chk("pend_nrd", rd_cyc.size(), 6);
    if (rd_cyc.size() == 6) begin
      chk("pend_rdcyc", rd_cyc[3], t0 + 7);
      chk("pend_rdlay", rd_lay[3], 3);
    end
    chk("pend_nwr", wr_cyc.size(), 6);

    // Overflow: third strobe dropped.
    do_reset();
    t0 = cyc;
    tick(1, 1, 0, 2, rnd48());
    idle(1);
    tick(1, 1, 1, 2, rnd48());
    idle(1);
    tick(1, 1, 2, 2, rnd48());
    chk("ovf_before", overflow, 0);
    idle(1);
    chk("ovf_after", overflow, 1);
    idle(16);
    chk("ovf_nwr", wr_cyc.size(), 6);
    chk("ovf_count", update_count, 2);
    chk("ovf_sticky", overflow, 1);

    // Strobe coincident with last write, pending empty.
    do_reset();
    t0 = cyc;
    tick(1, 1, 0, 3, rnd48());
    idle(5);
    tick(1, 1, 7, 3, rnd48());
    idle(10);
    chk("simul_nrd", rd_cyc.size(), 6);
    if (rd_cyc.size() == 6) begin
      chk("simul_rdcyc", rd_cyc[3], t0 + 7);
      chk("simul_rdlay", rd_lay[3], 7);
    end
    chk("simul_ovf", overflow, 0);

    // Reset mid-row.
    do_reset();
    t0 = cyc;
    tick(1, 1, 1, 4, rnd48());
    idle(2);
    tick(0, 0, 0, 0, 0);
    #1;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col", mem_col, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    idle(8);
    chk("rst_nwr", wr_cyc.size(), 1);
    chk("rst_count", update_count, 0);

    // Randomized traffic with occasional resets.
    mode_dense = 1;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) mode_dense = $urandom_range(0, 1);
      if ($urandom_range(0, 249) == 0) begin
        tick(0, 0, $urandom(), $urandom(), rnd48());
        if ($urandom_range(0, 1) == 1) tick(0, 0, 0, 0, 0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          case ($urandom_range(0, 3))
            0: lanes[k] = 16'h7FFF;
            1: lanes[k] = 16'h8000;
            default: lanes[k] = 16'($urandom());
          endcase
        end
        rdw = {lanes[2], lanes[1], lanes[0]};
        tick(1, mode_dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0),
             $urandom(), $urandom(), rdw);
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
